// File: rtl/johnson_decoder_pkg.sv
// Shared FSM state encoding and Johnson code generator for the decoder slice.
package johnson_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Code for index k of an n-stage counter, right-aligned in 32 bits
  function automatic logic [31:0] johnson_code(input int unsigned n, input int unsigned k);
    logic [31:0] ones;
    if (k <= n) begin
      ones         = (32'd1 << k) - 32'd1;
      johnson_code = ones << (n - k);
    end else begin
      johnson_code = (32'd1 << (2 * n - k)) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/johnson_code_lookup.sv
// Combinational Johnson code -> {legal, index} lookup; zero latency, no flow control.
module johnson_code_lookup
  import johnson_decoder_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(2 * N)
) (
  input  logic [N-1:0]     i_jc,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_legal = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if ({{(32 - N){1'b0}}, i_jc} == johnson_code(N, k)) begin
        o_legal = 1'b1;
        o_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder with sequence lock FSM and saturating error counter.
// 1-cycle registered latency; no backpressure, every jc_valid cycle is consumed.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int LOCK_COUNT = 3,
  parameter  int ERR_W      = 8,
  localparam int IDX_W      = $clog2(2 * N),
  localparam int SEQ_LEN    = 2 * N,
  localparam int CNT_W      = $clog2(LOCK_COUNT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       jc_in,
  input  logic               jc_valid,
  input  logic               clr_err,
  output logic [IDX_W-1:0]   idx,
  output logic [SEQ_LEN-1:0] onehot,
  output logic               idx_valid,
  output logic               locked,
  output logic               illegal,
  output logic               seq_err,
  output logic [ERR_W-1:0]   err_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_good_cnt;
  logic [CNT_W-1:0]   w_good_nxt;
  logic [CNT_W-1:0]   w_good_inc;
  logic [IDX_W-1:0]   r_prev_idx;
  logic [IDX_W-1:0]   w_succ_idx;
  logic [IDX_W-1:0]   r_idx;
  logic [SEQ_LEN-1:0] r_onehot;
  logic [SEQ_LEN-1:0] w_onehot;
  logic               r_idx_valid;
  logic               r_locked;
  logic               r_illegal;
  logic               r_seq_err;
  logic [ERR_W-1:0]   r_err_count;
  logic [ERR_W-1:0]   w_err_nxt;
  logic               w_legal;
  logic [IDX_W-1:0]   w_idx;
  logic               w_succ;
  logic               w_seq_err;
  logic               w_err_evt;

  johnson_code_lookup #(.N(N)) u_lookup (
    .i_jc    (jc_in),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  // Successor wraps 2N-1 -> 0
  assign w_succ_idx = (r_prev_idx == IDX_W'(SEQ_LEN - 1)) ? '0 : r_prev_idx + 1'b1;
  assign w_succ     = (w_idx == w_succ_idx);
  assign w_good_inc = r_good_cnt + 1'b1;

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_seq_err   = 1'b0;
    w_err_evt   = 1'b0;
    if (jc_valid) begin
      if (w_legal) begin
        case (r_state)
          HUNT: begin
            w_state_nxt = CHECK;
            w_good_nxt  = '0;
          end
          CHECK: begin
            if (!w_succ) begin
              w_good_nxt = '0;
            end else if (w_good_inc == CNT_W'(LOCK_COUNT)) begin
              w_state_nxt = LOCKED;
              w_good_nxt  = '0;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end
          LOCKED: begin
            if (!w_succ) begin
              w_state_nxt = CHECK;
              w_good_nxt  = '0;
              w_seq_err   = 1'b1;
              w_err_evt   = 1'b1;
            end
          end
          default: begin
            w_state_nxt = HUNT;
            w_good_nxt  = '0;
          end
        endcase
      end else begin
        // Illegal codes only count as errors once the stream was trusted
        w_state_nxt = HUNT;
        w_good_nxt  = '0;
        w_err_evt   = (r_state == LOCKED);
      end
    end
  end

  // Clear takes effect before a same-cycle event is counted
  always_comb begin
    w_err_nxt = r_err_count;
    if (clr_err) begin
      w_err_nxt = w_err_evt ? ERR_W'(1) : '0;
    end else if (w_err_evt && (r_err_count != {ERR_W{1'b1}})) begin
      w_err_nxt = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_good_cnt  <= '0;
      r_prev_idx  <= '0;
      r_idx       <= '0;
      r_onehot    <= '0;
      r_idx_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_err_count <= w_err_nxt;
      if (jc_valid) begin
        if (w_legal) begin
          r_prev_idx <= w_idx;
          r_idx      <= w_idx;
        end
        r_idx_valid <= w_legal;
        r_onehot    <= w_legal ? w_onehot : '0;
        r_illegal   <= !w_legal;
        r_seq_err   <= w_seq_err;
        r_locked    <= (w_state_nxt == LOCKED);
      end else begin
        r_idx_valid <= 1'b0;
        r_onehot    <= '0;
        r_illegal   <= 1'b0;
        r_seq_err   <= 1'b0;
      end
    end
  end

  assign idx       = r_idx;
  assign onehot    = r_onehot;
  assign idx_valid = r_idx_valid;
  assign locked    = r_locked;
  assign illegal   = r_illegal;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: a scoreboard of expected outputs, one entry per driven cycle.
module tb_johnson_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] jc_in;
  logic       jc_valid;
  logic       clr_err;

  logic [2:0] idx_a;
  logic [7:0] onehot_a;
  logic       idx_valid_a, locked_a, illegal_a, seq_err_a;
  logic [7:0] err_a;

  logic [2:0] idx_b;
  logic [7:0] onehot_b;
  logic       idx_valid_b, locked_b, illegal_b, seq_err_b;
  logic [1:0] err_b;

  johnson_decoder #(.N(4), .LOCK_COUNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid), .clr_err(clr_err),
    .idx(idx_a), .onehot(onehot_a), .idx_valid(idx_valid_a), .locked(locked_a),
    .illegal(illegal_a), .seq_err(seq_err_a), .err_count(err_a)
  );

  johnson_decoder #(.N(4), .LOCK_COUNT(3), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid), .clr_err(clr_err),
    .idx(idx_b), .onehot(onehot_b), .idx_valid(idx_valid_b), .locked(locked_b),
    .illegal(illegal_b), .seq_err(seq_err_b), .err_count(err_b)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct {
    int idx;
    int onehot;
    int idx_valid;
    int locked;
    int illegal;
    int seq_err;
    int err8;
    int err2;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  string      step_tag = "init";
  logic [3:0] codes[8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] bad[5]   = '{4'b0101, 4'b1010, 4'b1001, 4'b0100, 4'b1101};

  int m_state, m_good, m_prev, m_idx, m_locked, m_err8, m_err2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", step_tag, tag, obs, exp_v);
    end
  endtask

  task automatic model(input logic [3:0] jc, input logic v, input logic clr, input logic rst,
                       output exp_t e);
    int  k;
    bit  legal;
    bit  evt;
    e = '{default: 0};
    evt = 0;
    if (!rst) begin
      m_state = 0; m_good = 0; m_prev = 0; m_idx = 0;
      m_locked = 0; m_err8 = 0; m_err2 = 0;
    end else begin
      if (v) begin
        legal = 0;
        k = 0;
        for (int j = 0; j < 8; j++) begin
          if (codes[j] == jc) begin
            legal = 1;
            k = j;
          end
        end
        if (legal) begin
          e.idx_valid = 1;
          e.onehot    = 1 << k;
          m_idx       = k;
          case (m_state)
            0: begin m_state = 1; m_good = 0; end
            1: begin
              if (k == (m_prev + 1) % 8) begin
                m_good++;
                if (m_good == 3) begin m_state = 2; m_good = 0; end
              end else begin
                m_good = 0;
              end
            end
            default: begin
              if (k != (m_prev + 1) % 8) begin
                m_state = 1; m_good = 0; e.seq_err = 1; evt = 1;
              end
            end
          endcase
          m_prev = k;
        end else begin
          e.illegal = 1;
          if (m_state == 2) evt = 1;
          m_state = 0;
          m_good  = 0;
        end
        m_locked = (m_state == 2) ? 1 : 0;
      end
      if (clr) begin
        m_err8 = evt ? 1 : 0;
        m_err2 = evt ? 1 : 0;
      end else if (evt) begin
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3) m_err2++;
      end
    end
    e.idx    = m_idx;
    e.locked = m_locked;
    e.err8   = m_err8;
    e.err2   = m_err2;
  endtask

  task automatic drive(input logic [3:0] jc, input logic v, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    jc_in    = jc;
    jc_valid = v;
    clr_err  = clr;
    model(jc, v, clr, rst, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("idx",       idx_a,       e.idx);
    check("onehot",    onehot_a,    e.onehot);
    check("idx_valid", idx_valid_a, e.idx_valid);
    check("locked",    locked_a,    e.locked);
    check("illegal",   illegal_a,   e.illegal);
    check("seq_err",   seq_err_a,   e.seq_err);
    check("err8",      err_a,       e.err8);
    check("err2",      err_b,       e.err2);
    check("locked_b",  locked_b,    e.locked);
  endtask

  task automatic good(input int k);
    drive(codes[k % 8], 1'b1, 1'b0, 1'b1);
  endtask

  // Anchor plus LOCK_COUNT successors
  task automatic relock();
    int k;
    k = (m_prev + 1) % 8;
    for (int i = 0; i < 4; i++) good(k + i);
  endtask

  initial begin
    reset = 1'b0; jc_in = 4'b0000; jc_valid = 1'b0; clr_err = 1'b0;

    step_tag = "reset";
    drive(4'b1100, 1'b1, 1'b0, 1'b0);
    drive(4'b1100, 1'b1, 1'b0, 1'b0);
    check("reset_locked", locked_a, 0);
    drive(4'b1100, 1'b1, 1'b0, 1'b1);
    check("first_idx", idx_a, 2);

    step_tag = "lock";
    for (int k = 0; k < 4; k++) good(k);
    check("locked_at_3", locked_a, 1);
    step_tag = "wrap";
    for (int k = 4; k < 9; k++) good(k);
    check("wrap_idx", idx_a, 0);

    step_tag = "skip";
    good(2);
    check("skip_err", err_a, 1);
    good(4);
    for (int k = 5; k < 9; k++) good(k);
    check("relocked", locked_a, 1);

    step_tag = "illegal";
    drive(4'b0101, 1'b1, 1'b0, 1'b1);
    check("ill_idx_held", idx_a, 0);
    drive(4'b0101, 1'b1, 1'b0, 1'b1);
    check("hunt_err_same", err_a, 2);
    relock();

    step_tag = "idle";
    repeat (3) drive(4'b1010, 1'b0, 1'b0, 1'b1);
    check("idle_locked", locked_a, 1);
    good(m_prev + 1);

    step_tag = "saturate";
    for (int i = 0; i < 5; i++) begin
      drive(bad[i], 1'b1, 1'b0, 1'b1);
      relock();
    end
    check("sat_err2", err_b, 3);
    check("err8_total", err_a, 7);

    step_tag = "clr_seq";
    drive(codes[(m_prev + 3) % 8], 1'b1, 1'b1, 1'b1);
    check("clr_err8", err_a, 1);
    drive(codes[(m_prev + 1) % 8], 1'b1, 1'b1, 1'b1);
    relock();

    step_tag = "mid_reset";
    drive(codes[(m_prev + 1) % 8], 1'b1, 1'b0, 1'b0);
    check("rst_locked", locked_a, 0);
    drive(4'b0111, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
